ws2812_strand_driver: RTL and testbench

Serial one-wire output stage for the LED strand. Fetches one 24-bit colour per LED from the upstream colour source (calibration FSM or normal display path) using a request/valid handshake, and serialises it as WS2812 NRZ pulses on the strand data pin. Frames repeat continuously, each followed by a latch gap. It sits directly downstream of the calibration FSM's colour outputs and drives the FPGA pin.

---
 rtl/ws2812_strand_driver.sv | 157 +++++++++++++++
 tb/tb_ws2812_strand_driver.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ws2812_strand_driver.sv
// WS2812 strand driver: prefetches one {G,R,B} colour per LED over a request/valid
// handshake and serialises it as NRZ pulses, with a latch gap after every frame.
module ws2812_strand_driver #(
  parameter int unsigned NUM_LEDS          = 50,
  parameter int unsigned LED_ADDRESS_WIDTH = 6,
  parameter int unsigned BIT_CYCLES        = 125,
  parameter int unsigned T0H_CYCLES        = 40,
  parameter int unsigned T1H_CYCLES        = 80,
  parameter int unsigned RESET_CYCLES      = 8000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   green_in,
  input  logic [7:0]                   red_in,
  input  logic [7:0]                   blue_in,
  input  logic                         color_valid,
  output logic [LED_ADDRESS_WIDTH:0]   next_led_request,
  output logic                         strand_out,
  output logic                         frame_done
);

  localparam int unsigned CntMax   = (RESET_CYCLES > BIT_CYCLES) ? RESET_CYCLES : BIT_CYCLES;
  localparam int unsigned CntWidth = $clog2(CntMax + 1);
  localparam int unsigned LedWidth = $clog2(NUM_LEDS + 1);
  localparam int unsigned ReqWidth = LED_ADDRESS_WIDTH + 1;

  localparam logic [CntWidth-1:0] GapEnd  = CntWidth'(RESET_CYCLES);
  localparam logic [CntWidth-1:0] BitEnd  = CntWidth'(BIT_CYCLES - 1);
  localparam logic [CntWidth-1:0] T0High  = CntWidth'(T0H_CYCLES);
  localparam logic [CntWidth-1:0] T1High  = CntWidth'(T1H_CYCLES);
  localparam logic [LedWidth-1:0] LastLed = LedWidth'(NUM_LEDS - 1);
  localparam logic [ReqWidth-1:0] LastReq = ReqWidth'(NUM_LEDS - 1);

  typedef enum logic [1:0] {StGap, StLoad, StBit} state_e;

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [23:0]          shift_q, shift_d;
  logic [4:0]           bit_idx_q, bit_idx_d;
  logic [LedWidth-1:0]  led_cnt_q, led_cnt_d;
  logic                 post_reset_q, post_reset_d;
  logic                 frame_done_q, frame_done_d;
  logic [23:0]          buf_q, buf_d;
  logic                 buf_full_q, buf_full_d;
  logic [ReqWidth-1:0]  req_q, req_d;
  logic                 settle_q, settle_d;
  logic                 load_take;
  logic                 capture;
  logic                 strand_bit;

  // Shifter FSM: gap timing, buffer hand-off and per-bit pulse shaping.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    led_cnt_d    = led_cnt_q;
    post_reset_d = post_reset_q;
    frame_done_d = 1'b0;
    load_take    = 1'b0;
    strand_bit   = 1'b0;
    unique case (state_q)
      StGap: begin
        if (cnt_q == GapEnd) begin
          state_d      = StLoad;
          cnt_d        = '0;
          // The gap right after reset ends no frame, so it raises no pulse.
          frame_done_d = ~post_reset_q;
          post_reset_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      StLoad: begin
        // Without a buffered colour the line idles low rather than sending junk.
        if (buf_full_q) begin
          load_take = 1'b1;
          shift_d   = buf_q;
          bit_idx_d = 5'd23;
          cnt_d     = '0;
          state_d   = StBit;
        end
      end
      StBit: begin
        strand_bit = (cnt_q < (shift_q[23] ? T1High : T0High));
        if (cnt_q == BitEnd) begin
          cnt_d = '0;
          if (bit_idx_q == 5'd0) begin
            if (led_cnt_q == LastLed) begin
              led_cnt_d = '0;
              state_d   = StGap;
            end else begin
              led_cnt_d = led_cnt_q + LedWidth'(1);
              state_d   = StLoad;
            end
          end else begin
            bit_idx_d = bit_idx_q - 5'd1;
            shift_d   = {shift_q[22:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      default: state_d = StGap;
    endcase
  end

  // Prefetch buffer: capture only outside the settle cycle that follows a request change.
  always_comb begin
    capture    = ~buf_full_q & color_valid & ~settle_q;
    buf_d      = capture ? {green_in, red_in, blue_in} : buf_q;
    settle_d   = capture;
    req_d      = req_q;
    buf_full_d = buf_full_q;
    if (load_take) begin
      buf_full_d = 1'b0;
    end else if (capture) begin
      buf_full_d = 1'b1;
      req_d      = (req_q == LastReq) ? '0 : req_q + ReqWidth'(1);
    end
  end

  // State registers; reset starts in the gap and treats cycle 0 as a settle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StGap;
      cnt_q        <= '0;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      led_cnt_q    <= '0;
      post_reset_q <= 1'b1;
      frame_done_q <= 1'b0;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      req_q        <= '0;
      settle_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      led_cnt_q    <= led_cnt_d;
      post_reset_q <= post_reset_d;
      frame_done_q <= frame_done_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      req_q        <= req_d;
      settle_q     <= settle_d;
    end
  end

  // Line level decodes straight from flops, so reset drops it without waiting for a clock.
  assign strand_out       = strand_bit;
  assign frame_done       = frame_done_q;
  assign next_led_request = req_q;

endmodule

// File: tb/tb_ws2812_strand_driver.sv
// Directed bench for ws2812_strand_driver with reduced timing parameters.
module tb_ws2812_strand_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] green_in, red_in, blue_in;
  logic       color_valid;
  logic [6:0] next_led_request;
  logic       strand_out;
  logic       frame_done;

  logic       stale = 1'b1;
  logic       valid_en = 1'b1;
  logic [6:0] u_idx = '0;
  logic       log_en = 1'b0;
  logic [6:0] req_last = '0;
  logic [6:0] req_log[$];

  int checks = 0;
  int errors = 0;
  int hi_cnt = 0;
  int n = 0;
  int e = 0;

  ws2812_strand_driver #(
    .NUM_LEDS(3), .LED_ADDRESS_WIDTH(6), .BIT_CYCLES(10),
    .T0H_CYCLES(3), .T1H_CYCLES(7), .RESET_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .green_in(green_in), .red_in(red_in), .blue_in(blue_in),
    .color_valid(color_valid),
    .next_led_request(next_led_request),
    .strand_out(strand_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] col_of(input logic [6:0] idx);
    case (idx)
      7'd0:    return 24'hFF00A5;
      7'd1:    return 24'h3C990F;
      7'd2:    return 24'h00FF5A;
      default: return 24'h123456;
    endcase
  endfunction

  // Upstream model: colour follows the request one clock late, so the settle cycle
  // still presents the previous index's colour.
  always @(posedge clk) u_idx <= next_led_request;
  assign {green_in, red_in, blue_in} = stale ? col_of(7'd2) : col_of(u_idx);
  assign color_valid = valid_en;

  // Request-change log for the sequence check.
  always @(negedge clk) begin
    if (log_en && next_led_request !== req_last) req_log.push_back(next_led_request);
    req_last = next_led_request;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic acc_low();
    if (strand_out !== 1'b0 || frame_done !== 1'b0) hi_cnt++;
  endtask

  // One LED: 24 bits MSB first, 10 samples per bit; a 1 is high 7 clocks, a 0 high 3.
  task automatic check_led(input logic [23:0] col, input string tag);
    logic [9:0] obs;
    logic [9:0] exp;
    int thr;
    for (int b = 23; b >= 0; b--) begin
      thr = col[b] ? 7 : 3;
      for (int j = 0; j < 10; j++) begin
        step();
        obs[j] = strand_out;
        exp[j] = (j < thr);
      end
      chk($sformatf("%s_bit%0d", tag, b), {22'd0, obs}, {22'd0, exp});
    end
  endtask

  initial begin
    // Reset with stale colours (index 2) presented on the inputs.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_strand", {31'd0, strand_out}, 0);
    chk("rst_frame_done", {31'd0, frame_done}, 0);
    chk("rst_req", {25'd0, next_led_request}, 0);
    repeat (3) @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    hi_cnt = 0;
    acc_low();
    chk("req_cycle0", {25'd0, next_led_request}, 0);
    step();
    acc_low();
    chk("req_settle", {25'd0, next_led_request}, 0);
    stale = 1'b0;
    step();
    acc_low();
    chk("capture_latency", {25'd0, next_led_request}, 1);
    repeat (18) begin step(); acc_low(); end
    chk("gap_after_reset", hi_cnt, 0);
    step();
    chk("load_low_first", {31'd0, strand_out}, 0);
    chk("no_fd_after_reset", {31'd0, frame_done}, 0);
    check_led(col_of(7'd0), "f1_led0");

    // Rest of frame 1, then gap and frame_done timing.
    step();
    chk("load_low_led1", {31'd0, strand_out}, 0);
    log_en = 1'b1;
    check_led(col_of(7'd1), "f1_led1");
    step();
    chk("load_low_led2", {31'd0, strand_out}, 0);
    check_led(col_of(7'd2), "f1_led2");
    hi_cnt = 0;
    repeat (21) begin step(); acc_low(); end
    chk("gap_frame1", hi_cnt, 0);
    step();
    chk("frame_done_pulse", {31'd0, frame_done}, 1);
    step();
    chk("frame_done_width", {31'd0, frame_done}, 0);
    n = 1;
    while (frame_done !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    chk("frame_period", n, 744);
    log_en = 1'b0;
    chk("req_log_len", {31'd0, req_log.size() >= 4}, 1);
    e = 0;
    foreach (req_log[i]) begin
      chk("req_seq", {25'd0, req_log[i]}, e);
      e = (e + 1) % 3;
    end

    // Underrun: LED1 colour withheld until well past its LOAD slot.
    valid_en = 1'b0;
    check_led(col_of(7'd0), "f3_led0");
    hi_cnt = 0;
    repeat (100) begin step(); acc_low(); end
    chk("underrun_low", hi_cnt, 0);
    chk("underrun_req_hold", {25'd0, next_led_request}, 1);
    valid_en = 1'b1;
    step();
    chk("underrun_load_low", {31'd0, strand_out}, 0);
    chk("underrun_capture", {25'd0, next_led_request}, 2);
    check_led(col_of(7'd1), "f3_led1");
    step();
    chk("f3_load_led2", {31'd0, strand_out}, 0);
    check_led(col_of(7'd2), "f3_led2");
    hi_cnt = 0;
    repeat (21) begin step(); acc_low(); end
    chk("gap_frame3", hi_cnt, 0);
    step();
    chk("frame_done_after_underrun", {31'd0, frame_done}, 1);

    // Reset during the high phase of LED1's 13th transmitted bit.
    check_led(col_of(7'd0), "f4_led0");
    step();
    repeat (122) step();
    chk("pre_reset_high", {31'd0, strand_out}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_strand", {31'd0, strand_out}, 0);
    chk("midreset_req", {25'd0, next_led_request}, 0);
    chk("midreset_frame_done", {31'd0, frame_done}, 0);
    repeat (3) @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    hi_cnt = 0;
    acc_low();
    chk("req_after_reset2", {25'd0, next_led_request}, 0);
    repeat (20) begin step(); acc_low(); end
    chk("gap_after_reset2", hi_cnt, 0);
    step();
    chk("no_fd_after_reset2", {31'd0, frame_done}, 0);
    check_led(col_of(7'd0), "r2_led0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
